modular_reduce_r: RTL and testbench

//   Sequential reducer: remainder = value mod modulus, by restoring shift-subtract, one dividend bit per clock.

---
 rtl/modular_reduce_r_if.sv | 33 +++
 rtl/modular_reduce_r.sv | 112 +++++++++++
 tb/tb_modular_reduce_r.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/modular_reduce_r_if.sv
// Operand/result bundle for modular_reduce_r; the quotient signal exists only
// when QUOTIENT_OUT_EN is defined.
interface modular_reduce_r_if #(
    parameter int DATA_W = 64,
    parameter int MOD_W  = 32
);
    logic              start;
    logic [DATA_W-1:0] value;
    logic [MOD_W-1:0]  modulus;
    logic [MOD_W-1:0]  remainder;
    logic              done;
    logic              busy;
    logic              err;
`ifdef QUOTIENT_OUT_EN
    logic [DATA_W-1:0] quotient;
`endif

    modport master (
        output start, value, modulus,
        input  remainder, done, busy, err
`ifdef QUOTIENT_OUT_EN
        , input quotient
`endif
    );

    modport slave (
        input  start, value, modulus,
        output remainder, done, busy, err
`ifdef QUOTIENT_OUT_EN
        , output quotient
`endif
    );
endinterface

// File: rtl/modular_reduce_r.sv
// Sequential restoring shift-subtract reducer: remainder = value mod modulus,
// one dividend bit per clock. Define QUOTIENT_OUT_EN to also produce the quotient.
module modular_reduce_r #(
    parameter int DATA_W = 64,
    parameter int MOD_W  = 32
) (
    input logic              clk,
    input logic              rst,
    modular_reduce_r_if.slave bus
);
    localparam int CNT_W = $clog2(DATA_W);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state, state_d;
    logic [DATA_W-1:0] value_sh;
    logic [MOD_W-1:0]  mod_r;
    logic [MOD_W-1:0]  p;
    logic [CNT_W-1:0]  cnt;
    logic [MOD_W-1:0]  remainder_r;
    logic              err_r;

    logic              accept;
    logic              last_bit;
    logic [MOD_W:0]    p_sh;
    logic              ge;
    logic [MOD_W-1:0]  p_next;

    assign accept   = (state == IDLE) && bus.start;
    assign last_bit = (cnt == '0);

    // The shifted partial remainder needs MOD_W+1 bits; after the restoring
    // step it is always below modulus, so only MOD_W bits are stored.
    assign p_sh   = {p, value_sh[DATA_W-1]};
    assign ge     = (p_sh >= {1'b0, mod_r});
    assign p_next = ge ? (p_sh[MOD_W-1:0] - mod_r) : p_sh[MOD_W-1:0];

    // NOTE: every signal written in this always_comb gets a default first,
    // otherwise an unassigned path infers a latch.
    always_comb begin
        state_d = state;
        unique case (state)
            IDLE: if (bus.start) state_d = (bus.modulus == '0) ? DONE : RUN;
            RUN:  if (last_bit)  state_d = DONE;
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            value_sh    <= '0;
            mod_r       <= '0;
            p           <= '0;
            cnt         <= '0;
            remainder_r <= '0;
            err_r       <= 1'b0;
        end else if (accept) begin
            value_sh <= bus.value;
            mod_r    <= bus.modulus;
            p        <= '0;
            cnt      <= CNT_W'(DATA_W - 1);
            if (bus.modulus == '0) begin
                err_r       <= 1'b1;
                remainder_r <= '0;
            end else begin
                err_r <= 1'b0;
            end
        end else if (state == RUN) begin
            value_sh <= value_sh << 1;
            p        <= p_next;
            cnt      <= cnt - 1'b1;
            if (last_bit) remainder_r <= p_next;
        end
    end

`ifdef QUOTIENT_OUT_EN
    logic [DATA_W-1:0] q_sh;
    logic [DATA_W-1:0] quotient_r;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_sh       <= '0;
            quotient_r <= '0;
        end else if (accept) begin
            q_sh <= '0;
            if (bus.modulus == '0) quotient_r <= '0;
        end else if (state == RUN) begin
            q_sh <= {q_sh[DATA_W-2:0], ge};
            if (last_bit) quotient_r <= {q_sh[DATA_W-2:0], ge};
        end
    end

    assign bus.quotient = quotient_r;
`endif

    assign bus.remainder = remainder_r;
    assign bus.err       = err_r;
    assign bus.done      = (state == DONE);
    assign bus.busy      = (state != IDLE);
endmodule

// File: tb/tb_modular_reduce_r.sv
// Directed bench for modular_reduce_r: known-answer reductions, zero modulus,
// ignored starts, back-to-back ops and mid-run reset.
module tb_modular_reduce_r;
    localparam int DATA_W = 64;
    localparam int MOD_W  = 32;

    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    modular_reduce_r_if #(.DATA_W(DATA_W), .MOD_W(MOD_W)) bus ();

    modular_reduce_r #(.DATA_W(DATA_W), .MOD_W(MOD_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    task automatic check_q(input string tag, input logic [63:0] exp);
`ifdef QUOTIENT_OUT_EN
        check(tag, bus.quotient, exp);
`else
        if (exp == 64'hDEAD) $display("no quotient %s", tag);
`endif
    endtask

    // Waits for done after the accepting edge; cycle 1 is the period right after it.
    task automatic wait_done(input string tag, output int lat);
        lat = 1;
        while (!bus.done && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!bus.done) check({tag, "_timeout"}, 64'd0, 64'd1);
    endtask

    task automatic run_op(input string tag, input logic [63:0] v, input logic [31:0] m,
                          input logic [31:0] exp_rem, input logic exp_err,
                          input logic [63:0] exp_q, input int exp_lat);
        int lat;
        @(negedge clk);
        bus.start = 1'b1; bus.value = v; bus.modulus = m;
        @(posedge clk); #1;
        bus.start = 1'b0;
        check({tag, "_busy"}, 64'(bus.busy), 64'd1);
        wait_done(tag, lat);
        check({tag, "_lat"}, 64'(lat), 64'(exp_lat));
        check({tag, "_rem"}, 64'(bus.remainder), 64'(exp_rem));
        check({tag, "_err"}, 64'(bus.err), 64'(exp_err));
        check_q({tag, "_q"}, exp_q);
        @(posedge clk); #1;
        check({tag, "_done_pulse"}, 64'(bus.done), 64'd0);
        check({tag, "_idle"}, 64'(bus.busy), 64'd0);
        check({tag, "_rem_hold"}, 64'(bus.remainder), 64'(exp_rem));
    endtask

    initial begin
        int lat;
        int busy_low;
        bus.start = 1'b0; bus.value = '0; bus.modulus = '0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_rem",  64'(bus.remainder), 64'd0);
        check("rst_done", 64'(bus.done), 64'd0);
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_err",  64'(bus.err), 64'd0);
        check_q("rst_q", 64'd0);
        @(negedge clk); rst = 1'b0;

        // T1..T4 plus small boundary cases
        run_op("t1",  64'd100, 32'd7, 32'd2, 1'b0, 64'd14, DATA_W + 1);
        run_op("t2",  64'd3486784401, 32'd23, 32'd18, 1'b0, 64'd151599321, DATA_W + 1);
        run_op("t3",  64'hFFFF_FFFF_FFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 1'b0, 64'h1_0000_0001, DATA_W + 1);
        run_op("t4z", 64'd5, 32'd0, 32'd0, 1'b1, 64'd0, 1);
        run_op("t4",  64'd9, 32'd4, 32'd1, 1'b0, 64'd2, DATA_W + 1);
        run_op("lt",  64'd5, 32'd9, 32'd5, 1'b0, 64'd0, DATA_W + 1);
        run_op("m1",  64'd12345, 32'd1, 32'd0, 1'b0, 64'd12345, DATA_W + 1);

        // T5: start pulses with other operands during RUN are ignored
        @(negedge clk);
        bus.start = 1'b1; bus.value = 64'd1000; bus.modulus = 32'd13;
        @(posedge clk); #1;
        bus.start = 1'b0;
        busy_low = 0;
        lat = 1;
        while (!bus.done && lat < 200) begin
            if (!bus.busy) busy_low++;
            @(negedge clk);
            bus.start = (lat % 7 == 3);
            bus.value = 64'd77; bus.modulus = 32'd5;
            @(posedge clk); #1;
            lat++;
        end
        bus.start = 1'b0;
        check("t5_busy_thru", 64'(busy_low), 64'd0);
        check("t5_lat", 64'(lat), 64'(DATA_W + 1));
        check("t5_rem", 64'(bus.remainder), 64'd12);
        check_q("t5_q", 64'd76);
        @(posedge clk); #1;
        check("t5_idle", 64'(bus.busy), 64'd0);

        // start held high: next op accepted right after DONE, DATA_W+2 cycles apart
        @(negedge clk);
        bus.start = 1'b1; bus.value = 64'd20; bus.modulus = 32'd6;
        @(posedge clk); #1;
        wait_done("b2b1", lat);
        check("b2b1_rem", 64'(bus.remainder), 64'd2);
        check_q("b2b1_q", 64'd3);
        bus.value = 64'd50; bus.modulus = 32'd7;
        @(posedge clk); #1;
        lat = 1;
        while (!bus.done && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        bus.start = 1'b0;
        check("b2b_period", 64'(lat), 64'(DATA_W + 2));
        check("b2b2_rem", 64'(bus.remainder), 64'd1);
        check_q("b2b2_q", 64'd7);
        @(posedge clk); #1;

        // T6: async reset at RUN cycle 30 aborts with no done pulse
        @(negedge clk);
        bus.start = 1'b1; bus.value = 64'd1000; bus.modulus = 32'd13;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (29) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("t6_rem",  64'(bus.remainder), 64'd0);
        check("t6_busy", 64'(bus.busy), 64'd0);
        check("t6_done", 64'(bus.done), 64'd0);
        check_q("t6_q", 64'd0);
        @(negedge clk); rst = 1'b0;
        lat = 0;
        repeat (70) begin
            @(posedge clk); #1;
            if (bus.done) lat++;
        end
        check("t6_no_done", 64'(lat), 64'd0);
        run_op("t6b", 64'd10, 32'd3, 32'd1, 1'b0, 64'd3, DATA_W + 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
